// File: rtl/gcd_pkg.sv
// Shared definitions for the Stein GCD custom instruction.
//   state_t      : operation sequencer states
//   MODE_GCD     : result is gcd(A,B)
//   MODE_COPRIME : result is 1 when gcd(A,B)==1, else 0
package gcd_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ALIGN  = 3'd1,
    STRIP  = 3'd2,
    REDUCE = 3'd3,
    FINISH = 3'd4
  } state_t;

  localparam logic MODE_GCD     = 1'b0;
  localparam logic MODE_COPRIME = 1'b1;

endpackage

// File: rtl/gcd_reduce_step.sv
// Combinational reduction step of Stein's algorithm.
//   a, b     : current working values
//   min_ab   : min(a,b)
//   abs_diff : |a-b|
//   equal    : a==b
// Keeps the comparator and subtractor out of the sequencer.
module gcd_reduce_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] min_ab,
  output logic [WIDTH-1:0] abs_diff,
  output logic             equal
);

  logic a_lt_b;

  always_comb begin
    a_lt_b   = (a < b);
    equal    = (a == b);
    min_ab   = a_lt_b ? a : b;
    abs_diff = a_lt_b ? (b - a) : (a - b);
  end

endmodule

// File: rtl/gcd_stein_ci.sv
// GCD / coprime-test custom instruction using Stein's binary algorithm,
// one algorithm step per enabled clock.
//   csi_clk, rsi_reset_n : clock, asynchronous active-low reset
//   clk_en               : global enable; everything freezes when low
//   avs_s0_write/_data   : load operand A
//   avs_s1_write/_data   : load operand B
//   avs_s2_read          : result read strobe (no side effects)
//   avs_mode             : sampled at start, 0 = GCD, 1 = coprime test
//   avs_start            : begin (or abort and restart) an operation
//   avs_s2_readdata      : result, held until the next completion
//   avs_done             : one-enabled-cycle completion pulse
//   avs_busy             : operation in progress
module gcd_stein_ci
  import gcd_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int KW    = $clog2(WIDTH + 1)
) (
  input  logic             csi_clk,
  input  logic             rsi_reset_n,
  input  logic             clk_en,
  input  logic             avs_s0_write,
  input  logic             avs_s1_write,
  input  logic             avs_s2_read,
  input  logic [WIDTH-1:0] avs_s0_writedata,
  input  logic [WIDTH-1:0] avs_s1_writedata,
  input  logic             avs_mode,
  input  logic             avs_start,
  output logic [WIDTH-1:0] avs_s2_readdata,
  output logic             avs_done,
  output logic             avs_busy
);

  state_t           state, state_next;
  logic [WIDTH-1:0] op_a, op_a_next, op_b, op_b_next;
  logic [WIDTH-1:0] a, a_next, b, b_next;
  logic [KW-1:0]    k, k_next;
  logic             mode, mode_next;
  logic [WIDTH-1:0] rdata, rdata_next;
  logic             done, done_next;
  logic             busy, busy_next;
  logic [WIDTH-1:0] shifted;
  logic [WIDTH-1:0] min_ab, abs_diff;
  logic             equal;
  logic             unused_read;

  // Reads are pure; the strobe is accepted but never changes state.
  assign unused_read = avs_s2_read;

  gcd_reduce_step #(.WIDTH(WIDTH)) u_step (
    .a        (a),
    .b        (b),
    .min_ab   (min_ab),
    .abs_diff (abs_diff),
    .equal    (equal)
  );

  always_comb begin
    state_next = state;
    a_next     = a;
    b_next     = b;
    k_next     = k;
    mode_next  = mode;
    rdata_next = rdata;
    done_next  = 1'b0;
    busy_next  = busy;
    // Writes coincident with start are forwarded into the start itself.
    op_a_next  = avs_s0_write ? avs_s0_writedata : op_a;
    op_b_next  = avs_s1_write ? avs_s1_writedata : op_b;
    shifted    = a << k;

    if (avs_start) begin
      // Start wins over everything, including a FINISH in progress.
      a_next    = op_a_next;
      b_next    = op_b_next;
      k_next    = '0;
      mode_next = avs_mode;
      busy_next = 1'b1;
      if (op_a_next == '0 || op_b_next == '0) begin
        a_next     = op_a_next | op_b_next;
        state_next = FINISH;
      end else begin
        state_next = ALIGN;
      end
    end else begin
      unique case (state)
        IDLE: ;
        ALIGN: begin
          // Pull out common factors of two, remembered in k.
          if (!a[0] && !b[0]) begin
            a_next = a >> 1;
            b_next = b >> 1;
            k_next = k + KW'(1);
          end else begin
            state_next = STRIP;
          end
        end
        STRIP: begin
          if (!a[0]) a_next = a >> 1;
          else       state_next = REDUCE;
        end
        REDUCE: begin
          // a is odd here; the difference of two odds is even, so b is
          // shifted down on the following steps.
          if (!b[0]) begin
            b_next = b >> 1;
          end else if (equal) begin
            state_next = FINISH;
          end else begin
            a_next = min_ab;
            b_next = abs_diff;
          end
        end
        FINISH: begin
          if (mode == MODE_COPRIME)
            rdata_next = {{(WIDTH-1){1'b0}}, (shifted == WIDTH'(1))};
          else
            rdata_next = shifted;
          done_next  = 1'b1;
          busy_next  = 1'b0;
          state_next = IDLE;
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge csi_clk or negedge rsi_reset_n) begin
    if (!rsi_reset_n) begin
      state <= IDLE;
      op_a  <= '0;
      op_b  <= '0;
      a     <= '0;
      b     <= '0;
      k     <= '0;
      mode  <= MODE_GCD;
      rdata <= '0;
      done  <= 1'b0;
      busy  <= 1'b0;
    end else if (clk_en) begin
      state <= state_next;
      op_a  <= op_a_next;
      op_b  <= op_b_next;
      a     <= a_next;
      b     <= b_next;
      k     <= k_next;
      mode  <= mode_next;
      rdata <= rdata_next;
      done  <= done_next;
      busy  <= busy_next;
    end
  end

  assign avs_s2_readdata = rdata;
  assign avs_done        = done;
  assign avs_busy        = busy;

endmodule

// File: tb/tb_gcd_stein_ci.sv
// Self-checking bench for gcd_stein_ci: expected results come from a
// Euclid-based reference model and are checked by a done-driven monitor.
module tb_gcd_stein_ci;

  localparam int W      = 32;
  localparam int W8     = 8;
  localparam int BUDGET = 2*W + 4;

  logic          clk    = 1'b0;
  logic          rst_n  = 1'b0;
  logic          clk_en = 1'b1;
  logic          wr_a = 1'b0, wr_b = 1'b0, rd = 1'b0, mode = 1'b0, start = 1'b0;
  logic [W-1:0]  wd_a = '0, wd_b = '0;
  logic [W-1:0]  rdata;
  logic          done, busy;

  logic          wr8_a = 1'b0, wr8_b = 1'b0, start8 = 1'b0;
  logic [W8-1:0] wd8_a = '0, wd8_b = '0;
  logic [W8-1:0] rdata8;
  logic          done8, busy8;

  int            checks    = 0;
  int            failures  = 0;
  int            done_cnt  = 0;
  int            issue_cnt = 0;
  logic          done_prev = 1'b0;
  logic [W-1:0]  expq[$];

  always #5 clk = ~clk;

  gcd_stein_ci #(.WIDTH(W)) dut (
    .csi_clk          (clk),
    .rsi_reset_n      (rst_n),
    .clk_en           (clk_en),
    .avs_s0_write     (wr_a),
    .avs_s1_write     (wr_b),
    .avs_s2_read      (rd),
    .avs_s0_writedata (wd_a),
    .avs_s1_writedata (wd_b),
    .avs_mode         (mode),
    .avs_start        (start),
    .avs_s2_readdata  (rdata),
    .avs_done         (done),
    .avs_busy         (busy)
  );

  gcd_stein_ci #(.WIDTH(W8)) dut8 (
    .csi_clk          (clk),
    .rsi_reset_n      (rst_n),
    .clk_en           (clk_en),
    .avs_s0_write     (wr8_a),
    .avs_s1_write     (wr8_b),
    .avs_s2_read      (1'b0),
    .avs_s0_writedata (wd8_a),
    .avs_s1_writedata (wd8_b),
    .avs_mode         (1'b0),
    .avs_start        (start8),
    .avs_s2_readdata  (rdata8),
    .avs_done         (done8),
    .avs_busy         (busy8)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Reference: Euclid's algorithm on plain integers.
  function automatic logic [W-1:0] ref_result(input logic [W-1:0] a, input logic [W-1:0] b,
                                              input logic m);
    longint unsigned x, y, t;
    x = a;
    y = b;
    while (y != 0) begin
      t = x % y;
      x = y;
      y = t;
    end
    if (m) return (x == 1) ? W'(1) : W'(0);
    return W'(x);
  endfunction

  // Monitor: every rising done must match the oldest pending expectation.
  always @(negedge clk) begin
    if (done && !done_prev) begin
      done_cnt++;
      check("queue_nonempty_at_done", (expq.size() > 0), 1);
      if (expq.size() > 0) check("result", rdata, expq.pop_front());
      check("busy_low_at_done", busy, 0);
    end
    done_prev <= done;
  end

  // Write operands (A optionally forwarded in the start cycle) then start.
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic m,
                       input bit fwd);
    clk_en = 1'b1;
    if (!fwd) begin wr_a = 1'b1; wd_a = a; end
    wr_b = 1'b1;
    wd_b = b;
    @(posedge clk); #1;
    wr_a = 1'b0;
    wr_b = 1'b0;
    if (fwd) begin wr_a = 1'b1; wd_a = a; end
    start = 1'b1;
    mode  = m;
    expq.delete();
    expq.push_back(ref_result(a, b, m));
    issue_cnt = done_cnt;
    @(posedge clk); #1;
    start = 1'b0;
    wr_a  = 1'b0;
  endtask

  // Latency counts enabled edges, including the edge that samples start.
  task automatic wait_done(input string name, input bit rand_en, output int lat);
    int raw;
    raw = 0;
    lat = 1;
    while (done_cnt == issue_cnt && raw < 20000 && lat <= BUDGET) begin
      if (rand_en) clk_en = ($urandom_range(0, 2) != 0);
      @(posedge clk);
      if (clk_en) lat++;
      raw++;
      @(negedge clk); #1;
    end
    clk_en = 1'b1;
    check({name, "_done_seen"}, (done_cnt != issue_cnt), 1);
    check({name, "_latency_bound"}, (lat <= BUDGET), 1);
  endtask

  task automatic run8(input logic [W8-1:0] a, input logic [W8-1:0] b, input string name);
    int n;
    logic [W-1:0] e;
    e = ref_result(W'(a), W'(b), 1'b0);
    wr8_a = 1'b1; wr8_b = 1'b1; wd8_a = a; wd8_b = b; start8 = 1'b1;
    @(posedge clk); #1;
    wr8_a = 1'b0; wr8_b = 1'b0; start8 = 1'b0;
    n = 0;
    while (!done8 && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    check({name, "_done"}, done8, 1);
    check(name, rdata8, e[W8-1:0]);
  endtask

  initial begin
    int lat;
    int base;
    logic [W-1:0] hold_val;

    // Reset state
    #1;
    check("reset_rdata", rdata, 0);
    check("reset_done", done, 0);
    check("reset_busy", busy, 0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_reset_busy", busy, 0);

    // Worked example and busy timing
    issue(32'd12, 32'd18, 1'b0, 1'b0);
    check("busy_after_start", busy, 1);
    wait_done("gcd_12_18", 1'b0, lat);

    // Zero-operand fast path: minimum latency
    issue(32'd0, 32'd35, 1'b0, 1'b0);
    wait_done("gcd_0_35", 1'b0, lat);
    check("min_latency_0_35", lat, 2);
    issue(32'd0, 32'd0, 1'b0, 1'b0);
    wait_done("gcd_0_0", 1'b0, lat);
    check("min_latency_0_0", lat, 2);
    issue(32'd0, 32'd0, 1'b1, 1'b0);
    wait_done("coprime_0_0", 1'b0, lat);

    // Coprime mode
    issue(32'd35, 32'd64, 1'b1, 1'b0);
    wait_done("coprime_35_64", 1'b0, lat);
    issue(32'd21, 32'd14, 1'b1, 1'b0);
    wait_done("coprime_21_14", 1'b0, lat);

    // Narrow instance
    run8(8'd255, 8'd170, "w8_255_170");
    run8(8'd128, 8'd64, "w8_128_64");

    // Abort and restart: only the second operation completes
    base = done_cnt;
    issue(32'd1071, 32'd462, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    issue(32'd48, 32'd180, 1'b0, 1'b0);
    wait_done("restart_48_180", 1'b0, lat);
    repeat (10) @(posedge clk);
    #1 check("single_done_on_restart", done_cnt - base, 1);

    // Write of A forwarded into the start cycle (previous opA is 48)
    issue(32'd100, 32'd75, 1'b0, 1'b1);
    wait_done("forward_100_75", 1'b0, lat);

    // Random clock-enable gaps, then done held while disabled
    issue(32'h8000_0000, 32'h4000_0000, 1'b0, 1'b0);
    wait_done("clk_en_gaps", 1'b1, lat);
    hold_val = rdata;
    clk_en = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      check("done_held_clk_en_low", done, 1);
    end
    check("rdata_held_clk_en_low", rdata, hold_val);
    clk_en = 1'b1;
    @(posedge clk); #1;
    check("done_cleared_after_enable", done, 0);
    check("rdata_stable_after_done", rdata, hold_val);

    // Randomized operations against the reference model
    for (int i = 0; i < 24; i++) begin
      logic [W-1:0] ra, rb;
      logic rm;
      ra = ($urandom >> $urandom_range(0, 31)) << $urandom_range(0, 4);
      rb = ($urandom >> $urandom_range(0, 31)) << $urandom_range(0, 4);
      if (i % 8 == 3) ra = '0;
      rm = 1'($urandom_range(0, 1));
      rd = 1'($urandom_range(0, 1));
      issue(ra, rb, rm, (i % 5 == 2));
      wait_done("random", 1'b0, lat);
    end
    rd = 1'b0;

    // Asynchronous reset mid-operation
    issue(32'h8000_0000, 32'h0000_0001, 1'b0, 1'b0);
    repeat (4) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_rdata", rdata, 0);
    check("async_rst_done", done, 0);
    check("async_rst_busy", busy, 0);
    expq.delete();
    base = done_cnt;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (BUDGET + 4) @(posedge clk);
    #1 check("no_done_after_reset", done_cnt - base, 0);
    issue(32'd9, 32'd6, 1'b0, 1'b0);
    wait_done("gcd_9_6_after_reset", 1'b0, lat);

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

endmodule

// File: doc/gcd_stein_ci.md
# gcd_stein_ci

Parametrised successor to the team's fixed-width GCD custom instruction, used as a NIOS custom-instruction / Avalon-MM slave. It computes the GCD of two WIDTH-bit unsigned operands with Stein's binary algorithm, one step per enabled clock. It adds several features:

- a coprime-test mode
- abort-and-restart on a new start
- a busy flag
- store-and-forward of operand writes into the start cycle

## Interface
Parameters:
- WIDTH, 32, operand/result width in bits (≥ 4)
- KW, $clog2(WIDTH+1), width of common-power-of-two counter k (derived, not overridden)

Ports:
- csi_clk  in  1  clock
- rsi_reset_n  in  1  asynchronous active-low reset
- clk_en  in  1  clock enable; all state and outputs hold when low
- avs_s0_write  in  1  load operand register A
- avs_s1_write  in  1  load operand register B
- avs_s2_read  in  1  result read strobe (no side effects)
- avs_s0_writedata  in  WIDTH  operand A
- avs_s1_writedata  in  WIDTH  operand B
- avs_mode  in  1  sampled at start: 0 = GCD, 1 = coprime test
- avs_start  in  1  begin operation
- avs_s2_readdata  out  WIDTH  result; holds until next completion
- avs_done  out  1  one-cycle completion pulse
- avs_busy  out  1  high while an operation is in progress

## Operation
- Operand registers opA/opB load on s0/s1 write when clk_en=1.
  - A write in the same cycle as start is forwarded: start uses the new writedata.
- State flow: IDLE → ALIGN → STRIP → REDUCE → FINISH → IDLE. Working regs a, b (WIDTH), k (KW), latched mode.
- Start (any state, clk_en=1): latch a=opA', b=opB', k=0, mode; clear done; set busy.
  - If a==0 or b==0, go straight to FINISH with a=a|b, k=0.
  - Otherwise go to ALIGN.
  - Start during busy aborts the current operation; no done is issued for it.
- ALIGN: if a[0]==0 and b[0]==0, then a>>=1, b>>=1, k+=1. Else go to STRIP.
- STRIP: if a[0]==0, then a>>=1. Else go to REDUCE.
- REDUCE:
  - if b[0]==0: b>>=1
  - else if a==b: go to FINISH
  - else: a=min(a,b), b=|a−b|
- FINISH:
  - mode 0: readdata = a<<k
  - mode 1: readdata = {0…, (a<<k)==1}
  - In both modes: done=1 for one cycle, busy=0, go to IDLE.
- Arithmetic is unsigned. a<<k never exceeds the original operands, so there is no overflow.
- gcd(0,0) = 0; the coprime result for (0,0) is 0.
- avs_s2_read has no effect on state. Readdata is stable from the done cycle until the next FINISH.

## Timing
- Reset values: readdata=0, done=0, busy=0, state IDLE, opA=opB=a=b=0, k=0.
- Asynchronous reset mid-operation clears everything immediately; no done follows.
- Each state transition/step consumes exactly one cycle with clk_en=1. Cycles with clk_en=0 are invisible: state and outputs are frozen, and done stays high if it was high.
- Minimum latency: done is high 2 enabled cycles after start (zero-operand case: start → FINISH → done).
- Worst case is bounded by about 2·WIDTH+3 enabled cycles. The bench checks against 2·WIDTH+4.
- busy rises in the cycle after start and falls in the same cycle done rises.
- Start coincident with done: the new operation wins; done is dropped that cycle.

## Structure
- Package gcd_pkg: state enum (IDLE, ALIGN, STRIP, REDUCE, FINISH) and mode constants MODE_GCD=1'b0, MODE_COPRIME=1'b1.
- One combinational sub-module, gcd_reduce_step (parameter WIDTH). It computes min(a,b), |a−b|, and the a==b flag, and keeps the comparator/subtractor out of the FSM.

## Test plan
- Reset, then write A=12, B=18, start with mode=0 → done pulse, readdata=6. Worked trace: ALIGN(6,9,k=1), STRIP(3), REDUCE… FINISH.
- A=0, B=35, start → done exactly 2 enabled cycles later, readdata=35. Then A=0, B=0 → readdata=0.
- mode=1: (35,64) → 1; (21,14) → 0. WIDTH=8 instance: (255,170) → 85, (128,64) → 64.
- Start (1071,462), restart after 3 cycles with (48,180) → exactly one done pulse, readdata=12. Also: s0 write of 100 in the same cycle as start with B=75 → 25.
- Toggle clk_en low for random cycles during (2^31,2^30) → result 2^30; done is held while clk_en is low. Latency in enabled cycles is ≤ 2·WIDTH+4.
- Assert rsi_reset_n low mid-operation → all outputs go to 0 asynchronously. No done afterwards. The next start (9,6) → 3.
